// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/response handshake between MEM stage and memory
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: EX/MEM and MEM/WB registers with timed-out memory handshake
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               ex_valid,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic               MemtoReg_in,
    input  logic               RegWrite_in,
    input  logic               BrLink_in,
    input  logic [63:0]        EX_ALU_Result,
    input  logic [63:0]        Read_Data2_in,
    input  logic [63:0]        PC_BL_in,
    input  logic [4:0]         EX_Rd,
    input  logic               forwardC,
    input  logic [63:0]        WB_fwd_data,

    mem_stage_if.master        mem,

    output logic               stall,
    output logic [63:0]        MEM_ALUResult,
    output logic [4:0]         MEM_Rd,
    output logic               MEM_RegWrite,
    output logic               WB_valid,
    output logic               WB_RegWrite,
    output logic [4:0]         WB_Rd,
    output logic [63:0]        WB_Data,
    output logic               mem_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    // EX/MEM register
    logic        ex_valid_q;
    logic        ex_memread_q;
    logic        ex_memwrite_q;
    logic        ex_memtoreg_q;
    logic        ex_regwrite_q;
    logic        ex_brlink_q;
    logic [63:0] ex_alu_q;
    logic [63:0] ex_wdata_q;
    logic [63:0] ex_pc_q;
    logic [4:0]  ex_rd_q;

    // MEM/WB register
    logic        wb_valid_q, wb_valid_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [63:0] wb_data_q, wb_data_d;

    logic        in_wait;
    logic        ack_hit;
    logic        timeout;
    logic        ex_memop_q;
    logic        new_memop;
    logic [63:0] ld_data;

    // Handshake decode, stall, and next-state values for the FSM and MEM/WB
    always_comb begin
        in_wait    = (state_q == S_WAIT);
        ex_memop_q = ex_valid_q & (ex_memread_q | ex_memwrite_q);
        new_memop  = ex_valid & (MemRead_in | MemWrite_in);
        // an ack in the last allowed cycle beats the timeout
        ack_hit    = in_wait & mem.mem_ack;
        timeout    = in_wait & ~mem.mem_ack & (cnt_q == 32'(ACK_TIMEOUT - 1));
        stall      = in_wait & ~mem.mem_ack & ~timeout;

        state_d = S_IDLE;
        if (stall || new_memop) begin
            state_d = S_WAIT;
        end
        cnt_d = stall ? (cnt_q + 32'd1) : 32'd0;
        err_d = err_q | timeout;

        ld_data       = ack_hit ? mem.mem_rdata : 64'd0;
        wb_valid_d    = ex_valid_q;
        wb_regwrite_d = ex_regwrite_q & ex_valid_q & ~timeout;
        wb_rd_d       = ex_rd_q;
        wb_data_d     = ex_brlink_q   ? ex_pc_q :
                        ex_memtoreg_q ? ld_data : ex_alu_q;
    end

    // Access FSM with wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // EX/MEM register: loads whenever the stage is not stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_brlink_q   <= 1'b0;
            ex_alu_q      <= 64'd0;
            ex_wdata_q    <= 64'd0;
            ex_pc_q       <= 64'd0;
            ex_rd_q       <= 5'd0;
        end else if (!stall) begin
            ex_valid_q    <= ex_valid;
            ex_memread_q  <= MemRead_in;
            ex_memwrite_q <= MemWrite_in;
            ex_memtoreg_q <= MemtoReg_in;
            ex_regwrite_q <= RegWrite_in;
            ex_brlink_q   <= BrLink_in;
            ex_alu_q      <= EX_ALU_Result;
            ex_wdata_q    <= forwardC ? WB_fwd_data : Read_Data2_in;
            ex_pc_q       <= PC_BL_in;
            ex_rd_q       <= EX_Rd;
        end
    end

    // MEM/WB register: takes the EX/MEM entry on every unstalled edge
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= 64'd0;
        end else if (!stall) begin
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
        end
    end

    assign mem.mem_req   = in_wait & ex_memop_q;
    assign mem.mem_we    = in_wait & ex_memwrite_q;
    assign mem.mem_addr  = in_wait ? ex_alu_q   : 64'd0;
    assign mem.mem_wdata = in_wait ? ex_wdata_q : 64'd0;

    assign MEM_ALUResult = ex_alu_q;
    assign MEM_Rd        = ex_rd_q;
    assign MEM_RegWrite  = ex_regwrite_q & ex_valid_q;
    assign WB_valid      = wb_valid_q;
    assign WB_RegWrite   = wb_regwrite_q;
    assign WB_Rd         = wb_rd_q;
    assign WB_Data       = wb_data_q;
    assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a transaction model
module tb_mem_stage;
    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ex_valid, MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in, BrLink_in;
    logic [63:0] EX_ALU_Result, Read_Data2_in, PC_BL_in, WB_fwd_data;
    logic [4:0]  EX_Rd;
    logic        forwardC;
    logic        stall;
    logic [63:0] MEM_ALUResult;
    logic [4:0]  MEM_Rd;
    logic        MEM_RegWrite;
    logic        WB_valid, WB_RegWrite;
    logic [4:0]  WB_Rd;
    logic [63:0] WB_Data;
    logic        mem_err;

    mem_stage_if mif();

    mem_stage #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .BrLink_in(BrLink_in),
        .EX_ALU_Result(EX_ALU_Result), .Read_Data2_in(Read_Data2_in), .PC_BL_in(PC_BL_in),
        .EX_Rd(EX_Rd), .forwardC(forwardC), .WB_fwd_data(WB_fwd_data),
        .mem(mif.master),
        .stall(stall), .MEM_ALUResult(MEM_ALUResult), .MEM_Rd(MEM_Rd),
        .MEM_RegWrite(MEM_RegWrite), .WB_valid(WB_valid), .WB_RegWrite(WB_RegWrite),
        .WB_Rd(WB_Rd), .WB_Data(WB_Data), .mem_err(mem_err)
    );

    typedef struct {
        logic        valid, mr, mw, mtr, rw, bl;
        logic [63:0] alu, wd, pc;
        logic [4:0]  rd;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: the instruction in EX/MEM, the last retired one, and access progress
    ent_t        m_ex, m_new, m_zero;
    logic        m_wb_valid, m_wb_rw, m_err;
    logic [4:0]  m_wb_rd;
    logic [63:0] m_wb_data;
    int          m_cyc, m_delay;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_memop(input ent_t e);
        return e.valid && (e.mr || e.mw);
    endfunction

    task automatic check_regs();
        logic busy;
        busy = is_memop(m_ex);
        chk("mem_req",   64'(mif.mem_req),   64'(busy));
        chk("mem_we",    64'(mif.mem_we),    64'(busy && m_ex.mw));
        chk("mem_addr",  mif.mem_addr,       busy ? m_ex.alu : 64'd0);
        chk("mem_wdata", mif.mem_wdata,      busy ? m_ex.wd  : 64'd0);
        chk("MEM_ALUResult", MEM_ALUResult,  m_ex.alu);
        chk("MEM_Rd",        64'(MEM_Rd),    64'(m_ex.rd));
        chk("MEM_RegWrite",  64'(MEM_RegWrite), 64'(m_ex.rw && m_ex.valid));
        chk("WB_valid",      64'(WB_valid),  64'(m_wb_valid));
        chk("WB_RegWrite",   64'(WB_RegWrite), 64'(m_wb_rw));
        chk("WB_Rd",         64'(WB_Rd),     64'(m_wb_rd));
        chk("WB_Data",       WB_Data,        m_wb_data);
        chk("mem_err",       64'(mem_err),   64'(m_err));
    endtask

    task automatic model_reset();
        m_ex = m_zero; m_wb_valid = 0; m_wb_rw = 0; m_wb_rd = 0; m_wb_data = 0;
        m_err = 0; m_cyc = 1; m_delay = 1;
    endtask

    initial begin
        logic busy, ack, to_e, st_e, do_rst, late_ack;
        int   k;
        m_zero = '{valid:0, mr:0, mw:0, mtr:0, rw:0, bl:0, alu:0, wd:0, pc:0, rd:0};
        reset = 1; ex_valid = 0; MemRead_in = 0; MemWrite_in = 0; MemtoReg_in = 0;
        RegWrite_in = 0; BrLink_in = 0; EX_ALU_Result = 0; Read_Data2_in = 0;
        PC_BL_in = 0; EX_Rd = 0; forwardC = 0; WB_fwd_data = 0;
        mif.mem_ack = 0; mif.mem_rdata = 0;
        model_reset();
        late_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("stall_reset", 64'(stall), 64'd0);
        reset = 0;

        for (int i = 0; i < 3000; i++) begin
            busy = is_memop(m_ex);
            // memory responder: ack on the planned cycle; stray acks while idle must be ignored
            if (busy) ack = (m_cyc == m_delay);
            else      ack = late_ack || ($urandom_range(0, 7) == 0);
            late_ack = 0;
            mif.mem_ack   = ack;
            mif.mem_rdata = {$urandom(), $urandom()};

            do_rst = ($urandom_range(0, 299) == 0) ||
                     (busy && m_cyc == 2 && m_delay > 2 && $urandom_range(0, 9) == 0);
            reset = do_rst;
            if (do_rst && busy) late_ack = 1;

            k = $urandom_range(0, 3);
            ex_valid      = ($urandom_range(0, 4) != 0);
            MemRead_in    = (k == 0);
            MemWrite_in   = (k == 1);
            MemtoReg_in   = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            RegWrite_in   = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            BrLink_in     = ($urandom_range(0, 7) == 0);
            EX_ALU_Result = {$urandom(), $urandom()};
            Read_Data2_in = {$urandom(), $urandom()};
            PC_BL_in      = {$urandom(), $urandom()};
            WB_fwd_data   = {$urandom(), $urandom()};
            EX_Rd         = 5'($urandom_range(0, 31));
            forwardC      = 1'($urandom_range(0, 1));
            #1;

            to_e = busy && !ack && (m_cyc == T);
            st_e = busy && !ack && !to_e;
            chk("stall", 64'(stall), 64'(st_e));

            m_new = '{valid:ex_valid, mr:MemRead_in, mw:MemWrite_in, mtr:MemtoReg_in,
                      rw:RegWrite_in, bl:BrLink_in, alu:EX_ALU_Result,
                      wd:(forwardC ? WB_fwd_data : Read_Data2_in), pc:PC_BL_in, rd:EX_Rd};

            if (do_rst) begin
                model_reset();
            end else if (!st_e) begin
                m_wb_valid = m_ex.valid;
                m_wb_rw    = m_ex.rw && m_ex.valid && !to_e;
                m_wb_rd    = m_ex.rd;
                m_wb_data  = m_ex.bl  ? m_ex.pc :
                             m_ex.mtr ? ((busy && ack) ? mif.mem_rdata : 64'd0) : m_ex.alu;
                if (to_e) m_err = 1;
                m_ex    = m_new;
                m_cyc   = 1;
                m_delay = $urandom_range(1, T + 2);
            end else begin
                m_cyc++;
            end

            @(posedge clk);
            #1;
            reset = 0;
            check_regs();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
Parameters:
REQ-001 SHALL provide parameter ACK_TIMEOUT, default 16: the maximum number of cycles mem_req is held without mem_ack before the access is aborted.
Ports (one clock; reset is synchronous and active-high):
REQ-002 SHALL provide clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide reset  in  1  synchronous, active-high.
REQ-004 SHALL provide ex_valid  in  1  EX holds a real instruction (0 = bubble).
REQ-005 SHALL provide MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in, BrLink_in  in  1 each  control bits from EX.
REQ-006 SHALL provide EX_ALU_Result  in  64  ALU result / memory address; Read_Data2_in  in  64  store data; PC_BL_in  in  64  link value; EX_Rd  in  5  destination register.
REQ-007 SHALL provide forwardC  in  1  and WB_fwd_data  in  64  store-data override from writeback.
REQ-008 SHALL provide mem_req  out  1, mem_we  out  1, mem_addr  out  64, mem_wdata  out  64, mem_ack  in  1, mem_rdata  in  64  data-memory handshake.
REQ-009 SHALL provide stall  out  1  freeze upstream stages this cycle.
REQ-010 SHALL provide MEM_ALUResult  out  64, MEM_Rd  out  5, MEM_RegWrite  out  1  EX/MEM register contents for forwarding.
REQ-011 SHALL provide WB_valid  out  1, WB_RegWrite  out  1, WB_Rd  out  5, WB_Data  out  64  MEM/WB register contents.
REQ-012 SHALL provide mem_err  out  1  sticky timeout flag.

Function
REQ-013 EX/MEM register SHALL capture all EX inputs on any edge where stall=0; store data captured = forwardC ? WB_fwd_data : Read_Data2_in; holds when stall=1.
REQ-014 Latched entry is a "mem op" iff its ex_valid=1 and (MemRead or MemWrite).
REQ-015 FSM states: IDLE (no outstanding access) and WAIT (access outstanding).
REQ-016 On an edge where EX/MEM loads a mem op, next state SHALL be WAIT; otherwise it SHALL be IDLE.
REQ-017 In WAIT: mem_req=1, mem_we=latched MemWrite, mem_addr=latched ALU result, mem_wdata=latched store data; in IDLE: all four SHALL be 0.
REQ-018 stall SHALL equal (state==WAIT) and not mem_ack and not timeout, combinationally.
REQ-019 When mem_ack=1 in WAIT, MEM/WB SHALL capture the entry on that edge, with load data = mem_rdata; EX/MEM loads the next entry on the same edge; back-to-back mem ops SHALL remain in WAIT.
REQ-020 A 32-bit wait counter SHALL clear when entering WAIT and increment each WAIT cycle without ack; timeout is asserted when the counter equals ACK_TIMEOUT-1 and mem_ack=0.
REQ-021 On timeout: mem_err SHALL set (sticky until reset); MEM/WB SHALL capture the entry with WB_RegWrite=0 and WB_valid=1; stall SHALL release that cycle.
REQ-022 mem_ack and timeout in the same cycle: ack SHALL win and mem_err SHALL remain unchanged.
REQ-023 mem_ack while IDLE SHALL be ignored.
REQ-024 Non-mem entry: MEM/WB SHALL capture it on the next edge where stall=0; total latency from EX is 2 edges.
REQ-025 WB_Data SHALL be BrLink ? PC_BL : MemtoReg ? load data : ALU result.
REQ-026 WB_RegWrite SHALL be latched RegWrite AND valid; bubbles SHALL write WB_valid=0 and WB_RegWrite=0.
REQ-027 MEM_RegWrite SHALL be latched RegWrite AND EX/MEM valid.

Reset
REQ-028 While reset=1 at an edge, all EX/MEM and MEM/WB fields, the counter, and mem_err SHALL be cleared to 0, and state SHALL go to IDLE; mem_req=0 and stall=0 from the next cycle.
REQ-029 Reset during WAIT SHALL abandon the access with no MEM/WB write, and the late mem_ack SHALL be ignored.

Verification
REQ-030 ADD: ex_valid=1, RegWrite=1, ALU=0x2A, Rd=3 -> two edges later WB_valid=1, WB_Rd=3, WB_Data=0x2A; stall never asserted.
REQ-031 LDUR: addr 0x100, mem_ack after 3 req cycles, rdata=0xDEAD -> stall high for 2 cycles; WB_Data=0xDEAD on the ack edge; mem_addr=0x100 throughout.
REQ-032 STUR with forwardC=1, WB_fwd_data=0x77, Read_Data2_in=0x11 -> mem_we=1, mem_wdata=0x77; WB_RegWrite=0.
REQ-033 Load with no ack, ACK_TIMEOUT=4 -> mem_req high for 4 cycles, then mem_err=1, stall=0, WB_RegWrite=0; mem_err stays 1 until reset.
REQ-034 Two consecutive loads, each acked on its first cycle -> mem_req stays high, stall=0, WB captures rdata on consecutive edges.
REQ-035 Reset asserted in the 2nd WAIT cycle, ack arriving 1 cycle later -> all outputs 0, WB_valid=0, no write.
